// File: rtl/dmem_responder_pkg.sv
// Purpose    : shared encodings for the data-memory responder (MemOP, FSM states, request bundle).
// Latency    : n/a (types and constants only).
// Backpressure: n/a.
// Contents   : MOP_* func3 encodings, state_t, req_t, default base address, op legality helper.
package dmem_responder_pkg;

  localparam int unsigned MOP_BITS = 3;

  // MemOP values follow RISC-V func3 for loads/stores.
  localparam logic [MOP_BITS-1:0] MOP_B  = 3'b000;
  localparam logic [MOP_BITS-1:0] MOP_H  = 3'b001;
  localparam logic [MOP_BITS-1:0] MOP_W  = 3'b010;
  localparam logic [MOP_BITS-1:0] MOP_BU = 3'b100;
  localparam logic [MOP_BITS-1:0] MOP_HU = 3'b101;

  localparam logic [31:0] DMEM_ADDR_BASE_DFLT = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // One captured request; held for the whole transaction.
  typedef struct packed {
    logic                wr;
    logic [MOP_BITS-1:0] op;
    logic [31:0]         addr;
    logic [31:0]         wdata;
  } req_t;

  // Unsigned sub-word ops exist only for loads.
  function automatic logic op_legal(input logic wr, input logic [MOP_BITS-1:0] op);
    case (op)
      MOP_B, MOP_H, MOP_W: return 1'b1;
      MOP_BU, MOP_HU:      return !wr;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Purpose    : load/store request + response channel between core memory stage and responder.
// Latency    : n/a (wiring only).
// Backpressure: req_valid/req_ready and rsp_valid/rsp_ready handshakes.
// Ports      : master drives req_*, rsp_ready; slave drives req_ready, rsp_valid, rsp_rdata, rsp_err.
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_wr;
  logic [MOP_BITS-1:0] req_op;
  logic [31:0]         req_addr;
  logic [31:0]         req_wdata;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_rdata;
  logic                rsp_err;

  modport master (
    output req_valid, req_wr, req_op, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_op, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_responder_lane_align.sv
// Purpose    : byte-lane steering for one access: write mask, shifted store data, extended load data.
// Latency    : combinational.
// Backpressure: none.
// Ports      : i_op/i_lane/i_word/i_wdata in; o_wmask/o_wdata_sh/o_rdata_ext/o_misalign out.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [MOP_BITS-1:0] i_op,
  input  logic [1:0]          i_lane,
  input  logic [31:0]         i_word,
  input  logic [31:0]         i_wdata,
  output logic [3:0]          o_wmask,
  output logic [31:0]         o_wdata_sh,
  output logic [31:0]         o_rdata_ext,
  output logic                o_misalign
);

  logic [31:0] w_word_shr;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Bring the addressed lane down to bit 0 once; byte and half pick from there.
  assign w_word_shr = i_word >> {i_lane, 3'b000};
  assign w_byte     = w_word_shr[7:0];
  assign w_half     = w_word_shr[15:0];

  always_comb begin
    o_wmask     = 4'b0000;
    o_wdata_sh  = 32'h0;
    o_rdata_ext = 32'h0;
    o_misalign  = 1'b0;
    case (i_op)
      MOP_B, MOP_BU: begin
        o_wmask     = 4'b0001 << i_lane;
        // Replicating the byte puts it under whichever lane the mask enables.
        o_wdata_sh  = {4{i_wdata[7:0]}};
        o_rdata_ext = (i_op == MOP_B) ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
      end
      MOP_H, MOP_HU: begin
        o_misalign  = i_lane[0];
        o_wmask     = i_lane[1] ? 4'b1100 : 4'b0011;
        o_wdata_sh  = {2{i_wdata[15:0]}};
        o_rdata_ext = (i_op == MOP_H) ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
      end
      MOP_W: begin
        o_misalign  = |i_lane;
        o_wmask     = 4'b1111;
        o_wdata_sh  = i_wdata;
        o_rdata_ext = i_word;
      end
      default: begin
        o_wmask = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Purpose    : multi-cycle data-memory responder; one outstanding load/store on an internal word array.
// Latency    : rsp_valid rises LATENCY edges after the request accept edge.
// Backpressure: req_ready low from accept until the cycle after the response handshake; response held while rsp_ready low.
// Ports      : clk, rst (async active-low), bus (slave modport of dmem_responder_if).
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] ADDR_BASE   = DMEM_ADDR_BASE_DFLT,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) << 2;
  // WAIT runs LATENCY-1 cycles; the RESP-entry edge is the last one, hence -2.
  localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_enter_resp;
  req_t        r_req;
  req_t        w_cur;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic [31:0]      w_off;
  logic [IDX_W-1:0] w_idx;
  logic             w_oor;
  logic             w_illegal;
  logic             w_err;
  logic             w_commit;
  logic [31:0]      w_rword;
  logic [3:0]       w_wmask;
  logic [31:0]      w_wdata_sh;
  logic [31:0]      w_rdata_ext;
  logic             w_misalign;

  // With LATENCY==1 the access happens on the accept edge itself, so decode
  // must look at the live bus while idle and at the captured copy afterwards.
  assign w_cur = (r_state == S_IDLE)
               ? req_t'{wr: bus.req_wr, op: bus.req_op, addr: bus.req_addr, wdata: bus.req_wdata}
               : r_req;

  assign w_off     = w_cur.addr - ADDR_BASE;
  assign w_idx     = w_off[IDX_W+1:2];
  assign w_oor     = (w_cur.addr < ADDR_BASE) || ({1'b0, w_off} >= LIMIT);
  assign w_illegal = !op_legal(w_cur.wr, w_cur.op);
  assign w_rword   = r_mem[w_idx];
  assign w_err     = w_oor || w_illegal || w_misalign;

  dmem_lane_align u_lane_align (
    .i_op        (w_cur.op),
    .i_lane      (w_cur.addr[1:0]),
    .i_word      (w_rword),
    .i_wdata     (w_cur.wdata),
    .o_wmask     (w_wmask),
    .o_wdata_sh  (w_wdata_sh),
    .o_rdata_ext (w_rdata_ext),
    .o_misalign  (w_misalign)
  );

  // Next-state / counter logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY == 1) begin
            w_state_nxt  = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt  = S_RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Request capture and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req   <= '0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && bus.req_valid) begin
        r_req <= w_cur;
      end
      if (w_enter_resp) begin
        r_rdata <= (w_err || w_cur.wr) ? 32'h0 : w_rdata_ext;
        r_err   <= w_err;
      end else if (r_state == S_RESP && bus.rsp_ready) begin
        r_rdata <= 32'h0;
        r_err   <= 1'b0;
      end
    end
  end

  // Store commit; gated by rst so an edge during reset can never write.
  assign w_commit = w_enter_resp && w_cur.wr && !w_err && rst;

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wmask[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
        end
      end
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Purpose    : directed bench for dmem_responder with a response scoreboard (LATENCY=2 and LATENCY=4 instances).
// Latency    : checks rsp_valid arrives LATENCY edges after accept.
// Backpressure: exercises held responses with rsp_ready low and a pending second request.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic rst2;
  logic rst4;

  logic                t_sel;   // 0 -> LATENCY=2 instance, 1 -> LATENCY=4 instance
  logic                t_valid;
  logic                t_wr;
  logic [MOP_BITS-1:0] t_op;
  logic [31:0]         t_addr;
  logic [31:0]         t_wdata;
  logic                t_rsp_ready;

  logic        m_req_ready;
  logic        m_rsp_valid;
  logic [31:0] m_rsp_rdata;
  logic        m_rsp_err;

  int   checks;
  int   errors;
  exp_t sb_q[$];

  dmem_responder_if if2 ();
  dmem_responder_if if4 ();

  assign if2.req_valid = t_valid & ~t_sel;
  assign if2.req_wr    = t_wr;
  assign if2.req_op    = t_op;
  assign if2.req_addr  = t_addr;
  assign if2.req_wdata = t_wdata;
  assign if2.rsp_ready = t_rsp_ready;

  assign if4.req_valid = t_valid & t_sel;
  assign if4.req_wr    = t_wr;
  assign if4.req_op    = t_op;
  assign if4.req_addr  = t_addr;
  assign if4.req_wdata = t_wdata;
  assign if4.rsp_ready = t_rsp_ready;

  assign m_req_ready = t_sel ? if4.req_ready : if2.req_ready;
  assign m_rsp_valid = t_sel ? if4.rsp_valid : if2.rsp_valid;
  assign m_rsp_rdata = t_sel ? if4.rsp_rdata : if2.rsp_rdata;
  assign m_rsp_err   = t_sel ? if4.rsp_err   : if2.rsp_err;

  dmem_responder #(.LATENCY(2), .ADDR_BASE(32'h8000_0000), .DEPTH_WORDS(1024)) u_dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (if2)
  );

  dmem_responder #(.LATENCY(4), .ADDR_BASE(32'h8000_0000), .DEPTH_WORDS(1024)) u_dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (m_req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk({tag, "_ready_timeout"}, {31'h0, m_req_ready}, 32'h1);
  endtask

  // Returns the number of edges since the accept edge when rsp_valid is first seen.
  task automatic wait_rsp(input string tag, output int lat);
    lat = 1;
    while (m_rsp_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 50) chk({tag, "_rsp_timeout"}, {31'h0, m_rsp_valid}, 32'h1);
  endtask

  // Drive a request at a negedge, hold until the accept edge, return at the following negedge.
  task automatic issue(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input string tag);
    @(negedge clk);
    t_wr = wr; t_op = op; t_addr = addr; t_wdata = wdata; t_valid = 1'b1;
    wait_ready(tag);
    @(posedge clk);
    @(negedge clk);
    t_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    e = sb_q.pop_front();
    chk({tag, "_rdata"}, m_rsp_rdata, e.rdata);
    chk({tag, "_err"}, {31'h0, m_rsp_err}, {31'h0, e.err});
  endtask

  task automatic txn(input string tag, input logic wr, input logic [2:0] op,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    sb_q.push_back('{exp_rdata, exp_err});
    t_rsp_ready = 1'b1;
    issue(wr, op, addr, wdata, tag);
    wait_rsp(tag, lat);
    chk({tag, "_lat"}, lat, t_sel ? 32'd4 : 32'd2);
    pop_check(tag);
    @(negedge clk);
    chk({tag, "_ready_after"}, {31'h0, m_req_ready}, 32'h1);
  endtask

  initial begin
    exp_t e;
    int   lat;
    checks = 0;
    errors = 0;
    t_sel = 1'b0; t_valid = 1'b0; t_wr = 1'b0; t_op = 3'b000;
    t_addr = 32'h0; t_wdata = 32'h0; t_rsp_ready = 1'b1;
    rst2 = 1'b0; rst4 = 1'b0;

    // Reset values on both instances.
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      t_sel = s[0];
      #1;
      chk("rst_req_ready", {31'h0, m_req_ready}, 32'h1);
      chk("rst_rsp_valid", {31'h0, m_rsp_valid}, 32'h0);
      chk("rst_rsp_rdata", m_rsp_rdata, 32'h0);
      chk("rst_rsp_err",   {31'h0, m_rsp_err}, 32'h0);
    end
    t_sel = 1'b0;
    @(negedge clk);
    rst2 = 1'b1; rst4 = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'h0, m_req_ready}, 32'h1);

    // Store then sub-word loads.
    txn("sw_10",  1'b1, MOP_W,  32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
    txn("lw_10",  1'b0, MOP_W,  32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
    txn("lb_13",  1'b0, MOP_B,  32'h8000_0013, 32'h0, 32'hFFFF_FFDE, 1'b0);
    txn("lbu_13", 1'b0, MOP_BU, 32'h8000_0013, 32'h0, 32'h0000_00DE, 1'b0);
    txn("lh_12",  1'b0, MOP_H,  32'h8000_0012, 32'h0, 32'hFFFF_DEAD, 1'b0);
    txn("lhu_10", 1'b0, MOP_HU, 32'h8000_0010, 32'h0, 32'h0000_BEEF, 1'b0);

    // Partial stores preserve neighbouring lanes.
    txn("sb_11",  1'b1, MOP_B,  32'h8000_0011, 32'h1234_5655, 32'h0, 1'b0);
    txn("lw_sb",  1'b0, MOP_W,  32'h8000_0010, 32'h0, 32'hDEAD_55EF, 1'b0);
    txn("sh_12",  1'b1, MOP_H,  32'h8000_0012, 32'h0000_7777, 32'h0, 1'b0);
    txn("lw_sh",  1'b0, MOP_W,  32'h8000_0010, 32'h0, 32'h7777_55EF, 1'b0);

    // Errors: no data returned, no array change.
    txn("sw_top",   1'b1, MOP_W,  32'h8000_0FFC, 32'h0BAD_F00D, 32'h0, 1'b0);
    txn("sw_w0",    1'b1, MOP_W,  32'h8000_0000, 32'hCAFE_BABE, 32'h0, 1'b0);
    txn("lw_mis",   1'b0, MOP_W,  32'h8000_0011, 32'h0, 32'h0, 1'b1);
    txn("lh_mis",   1'b0, MOP_H,  32'h8000_0013, 32'h0, 32'h0, 1'b1);
    txn("sw_below", 1'b1, MOP_W,  32'h7FFF_FFFC, 32'h1212_1212, 32'h0, 1'b1);
    txn("lw_top",   1'b0, MOP_W,  32'h8000_0FFC, 32'h0, 32'h0BAD_F00D, 1'b0);
    txn("sw_above", 1'b1, MOP_W,  32'h8000_1000, 32'h3434_3434, 32'h0, 1'b1);
    txn("lw_w0",    1'b0, MOP_W,  32'h8000_0000, 32'h0, 32'hCAFE_BABE, 1'b0);
    txn("st_ill",   1'b1, MOP_BU, 32'h8000_0010, 32'hFFFF_FFFF, 32'h0, 1'b1);
    txn("ld_ill",   1'b0, 3'b011, 32'h8000_0010, 32'h0, 32'h0, 1'b1);
    txn("lw_after", 1'b0, MOP_W,  32'h8000_0010, 32'h0, 32'h7777_55EF, 1'b0);

    // Response backpressure with a second request waiting on the bus.
    sb_q.push_back('{32'h7777_55EF, 1'b0});
    sb_q.push_back('{32'h0000_00EF, 1'b0});
    t_rsp_ready = 1'b0;
    @(negedge clk);
    t_wr = 1'b0; t_op = MOP_W; t_addr = 32'h8000_0010; t_wdata = 32'h0; t_valid = 1'b1;
    wait_ready("bp1");
    @(posedge clk);
    @(negedge clk);
    t_op = MOP_BU;   // second request, valid stays high
    wait_rsp("bp1", lat);
    chk("bp1_lat", lat, 32'd2);
    e = sb_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", {31'h0, m_rsp_valid}, 32'h1);
      chk("bp_hold_rdata", m_rsp_rdata, e.rdata);
      chk("bp_hold_err",   {31'h0, m_rsp_err}, {31'h0, e.err});
      chk("bp_hold_ready", {31'h0, m_req_ready}, 32'h0);
      @(negedge clk);
    end
    chk("bp_last_rdata", m_rsp_rdata, e.rdata);
    t_rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_ready", {31'h0, m_req_ready}, 32'h1);
    chk("bp_idle_valid", {31'h0, m_rsp_valid}, 32'h0);
    @(negedge clk);
    chk("bp2_accepted", {31'h0, m_req_ready}, 32'h0);
    t_valid = 1'b0;
    wait_rsp("bp2", lat);
    chk("bp2_lat", lat, 32'd2);
    pop_check("bp2");
    @(negedge clk);

    // Reset during WAIT on the LATENCY=4 instance abandons the store.
    t_sel = 1'b1;
    txn("l4_sw_pre", 1'b1, MOP_W, 32'h8000_0020, 32'h1111_1111, 32'h0, 1'b0);
    issue(1'b1, MOP_W, 32'h8000_0020, 32'hAAAA_AAAA, "l4_sw_abort");
    chk("l4_in_wait", {31'h0, m_req_ready}, 32'h0);
    @(negedge clk);
    rst4 = 1'b0;
    #1;
    chk("l4_rst_ready", {31'h0, m_req_ready}, 32'h1);
    chk("l4_rst_valid", {31'h0, m_rsp_valid}, 32'h0);
    chk("l4_rst_rdata", m_rsp_rdata, 32'h0);
    chk("l4_rst_err",   {31'h0, m_rsp_err}, 32'h0);
    repeat (2) @(negedge clk);
    rst4 = 1'b1;
    @(negedge clk);
    txn("l4_lw_post", 1'b0, MOP_W, 32'h8000_0020, 32'h0, 32'h1111_1111, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the load/store interface driven by the core's MemWr/MemOP/ALUout/rs2 datapath.
- Accepts one request at a time over a valid/ready channel, holds it for a configurable access latency, then performs a byte/half/word read or write on an internal word array.
- Returns read data or an error over a valid/ready response channel.
- Sits between the core's memory stage and the data storage; also used standalone in simulation as a multi-cycle memory model.

Parameters:
- LATENCY, 2, cycles from request accept edge to rsp_valid high; legal range 1..15
- ADDR_BASE, 32'h80000000, byte address of word 0
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_wr  in  1  1=store, 0=load
- req_op  in  3  MemOP, RISC-V func3 encoding
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts the response
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
- rsp_err  out  1  misaligned, out-of-range or illegal op

Behaviour:
- Reset (rst low, async):
  - FSM to IDLE.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
  - Array contents are not reset.
  - Reset mid-WAIT abandons the request; a store not yet committed never writes.
- FSM states:
  - IDLE: req_ready=1. On req_valid&&req_ready, capture wr/op/addr/wdata. Go to RESP if LATENCY==1; otherwise load cnt=LATENCY-2 and go to WAIT.
  - WAIT: req_ready=0. When cnt==0, go to RESP; else cnt--.
  - RESP: req_ready=0, rsp_valid=1. rsp_rdata and rsp_err are stable until the handshake. On rsp_valid&&rsp_ready, go to IDLE.
- The memory access (read sample or store commit) happens on the edge entering RESP. Consequently, rsp_valid rises exactly LATENCY edges after the accept edge.
- No overlap: at most one outstanding request, and a new request is accepted no earlier than the cycle after the response handshake.
- Ops:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
  - Any other op, including 100/101 with req_wr=1, is illegal: rsp_err=1.
- Address decode:
  - off = addr - ADDR_BASE; word index = off[31:2]; lane = addr[1:0].
  - Out of range when addr < ADDR_BASE or off >= 4*DEPTH_WORDS: rsp_err=1.
- Alignment:
  - Half-word access requires addr[0]=0; word access requires addr[1:0]=0.
  - A violation sets rsp_err=1.
- Any error suppresses the store (array unchanged) and forces rsp_rdata=0.
- Loads:
  - Select the byte/half from lane.
  - lb/lh sign-extend; lbu/lhu zero-extend.
- Stores:
  - Write only the selected lanes, taking byte data from req_wdata[7:0] and half data from [15:0].
  - Other lanes of the word are preserved.
- Inputs other than req_valid are ignored outside the IDLE accept cycle. rsp_ready is ignored when rsp_valid=0.

Decomposition:
- Shared package, also imported by CSG:
  - MemOP encodings (MOP_B, MOP_H, MOP_W, MOP_BU, MOP_HU).
  - FSM state encoding (S_IDLE, S_WAIT, S_RESP).
  - Default ADDR_BASE constant.
- Sub-module dmem_lane_align: combinational helper that, given op, lane, word and wdata, produces:
  - the 4-bit byte write mask,
  - the lane-shifted write data,
  - the extended load data,
  - the misalign flag.
- The responder instantiates one dmem_lane_align and keeps the FSM, counter and array.

Test Plan:
- Reset/latency: release rst, then sw 0xDEADBEEF to 0x80000010 with LATENCY=2 and rsp_ready=1 -> req_ready=1 after reset; rsp_valid high 2 edges after accept; rsp_err=0; req_ready back to 1 the cycle after the handshake.
- Sub-word loads on word 0xDEADBEEF at 0x80000010:
  - lb 0x80000013 -> 0xFFFFFFDE
  - lbu 0x80000013 -> 0x000000DE
  - lh 0x80000012 -> 0xFFFFDEAD
  - lhu 0x80000010 -> 0x0000BEEF
- Partial store: sb 0x80000011 wdata 0x12345655, then lw 0x80000010 -> 0xDEAD55EF; sh 0x80000012 wdata 0x00007777, then lw -> 0x777755EF.
- Errors, each giving rsp_err=1, rsp_rdata=0, array unchanged (checked by a following lw returning the prior value):
  - lw 0x80000011 (misaligned)
  - sw 0x7FFFFFFC (below base)
  - sw 0x80001000 with DEPTH_WORDS=1024 (above range)
  - store op=100 (illegal)
- Response backpressure: hold rsp_ready=0 for 5 cycles, with req_valid held high carrying a second request -> rsp_valid, rsp_rdata and rsp_err stable; req_ready=0 throughout; second request accepted only the cycle after the handshake.
- Reset mid-operation: accept sw 0xAAAAAAAA to 0x80000020 with LATENCY=4, pulse rst low during WAIT -> outputs return to their reset values immediately; a later lw 0x80000020 returns the pre-existing value.
